// File: rtl/axis_job_feeder.sv
// axis_job_feeder: takes a wide job word, streams it out as an AXI-Stream frame on m00, then
// collects a fixed-length result frame from s00 into a wide result word that is held until
// the consumer takes it.
//
// Ports:
//   axis_aclk, axis_aresetn            clock, asynchronous active-low reset
//   job_data/job_valid/job_ready       wide job input (word j = bits [j*W +: W])
//   m00_axis_*                         outgoing job stream (tstrb tied to all ones)
//   s00_axis_*                         incoming result stream (tstrb ignored)
//   result_data/result_valid/result_ready  wide result output (word k = bits [k*W +: W])
//   rx_error                           framing error on the held result frame
//   jobs_done                          completed round trips, wraps at 16 bits
module axis_job_feeder #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH   = 32,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH   = 32,
  parameter int unsigned NUMBER_OF_JOB_WORDS    = 20,
  parameter int unsigned NUMBER_OF_RESULT_WORDS = 8
) (
  input  logic                                                axis_aclk,
  input  logic                                                axis_aresetn,
  input  logic [NUMBER_OF_JOB_WORDS*C_M_AXIS_TDATA_WIDTH-1:0] job_data,
  input  logic                                                job_valid,
  output logic                                                job_ready,
  output logic                                                m00_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]                     m00_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]                   m00_axis_tstrb,
  output logic                                                m00_axis_tlast,
  input  logic                                                m00_axis_tready,
  output logic                                                s00_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]                     s00_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]                   s00_axis_tstrb,
  input  logic                                                s00_axis_tlast,
  input  logic                                                s00_axis_tvalid,
  output logic [NUMBER_OF_RESULT_WORDS*C_S_AXIS_TDATA_WIDTH-1:0] result_data,
  output logic                                                result_valid,
  input  logic                                                result_ready,
  output logic                                                rx_error,
  output logic [15:0]                                         jobs_done
);

  localparam int unsigned TXW = (NUMBER_OF_JOB_WORDS > 1) ? $clog2(NUMBER_OF_JOB_WORDS) : 1;
  localparam int unsigned RXW = (NUMBER_OF_RESULT_WORDS > 1) ? $clog2(NUMBER_OF_RESULT_WORDS) : 1;
  localparam logic [TXW-1:0] TX_LAST = TXW'(NUMBER_OF_JOB_WORDS - 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(NUMBER_OF_RESULT_WORDS - 1);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_SEND        = 3'd1;
  localparam logic [2:0] S_WAIT_RESULT = 3'd2;
  localparam logic [2:0] S_DRAIN       = 3'd3;
  localparam logic [2:0] S_HOLD        = 3'd4;

  logic [2:0]                      r_state;
  logic [TXW-1:0]                  r_tx_ptr;
  logic [RXW-1:0]                  r_rx_ptr;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] r_job    [NUMBER_OF_JOB_WORDS];
  logic [C_S_AXIS_TDATA_WIDTH-1:0] r_result [NUMBER_OF_RESULT_WORDS];
  logic                            r_rx_error;
  logic [15:0]                     r_jobs_done;

  logic w_m00_hs;
  logic w_s00_hs;
  logic w_unused_strb;

  // Handshake qualifiers are all decoded from state, so no input reaches a ready/valid output.
  assign job_ready       = (r_state == S_IDLE);
  assign m00_axis_tvalid = (r_state == S_SEND);
  assign m00_axis_tlast  = (r_state == S_SEND) && (r_tx_ptr == TX_LAST);
  assign m00_axis_tdata  = r_job[r_tx_ptr];
  assign m00_axis_tstrb  = '1;
  assign s00_axis_tready = (r_state == S_WAIT_RESULT) || (r_state == S_DRAIN);
  assign result_valid    = (r_state == S_HOLD);
  assign rx_error        = r_rx_error;
  assign jobs_done       = r_jobs_done;

  assign w_m00_hs      = m00_axis_tvalid && m00_axis_tready;
  assign w_s00_hs      = s00_axis_tready && s00_axis_tvalid;
  assign w_unused_strb = ^s00_axis_tstrb;

  always_comb begin
    result_data = '0;
    for (int k = 0; k < int'(NUMBER_OF_RESULT_WORDS); k++) begin
      result_data[k*C_S_AXIS_TDATA_WIDTH +: C_S_AXIS_TDATA_WIDTH] = r_result[k];
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state     <= S_IDLE;
      r_tx_ptr    <= '0;
      r_rx_ptr    <= '0;
      r_rx_error  <= 1'b0;
      r_jobs_done <= '0;
      for (int j = 0; j < int'(NUMBER_OF_JOB_WORDS); j++) r_job[j] <= '0;
      for (int k = 0; k < int'(NUMBER_OF_RESULT_WORDS); k++) r_result[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            for (int j = 0; j < int'(NUMBER_OF_JOB_WORDS); j++) begin
              r_job[j] <= job_data[j*C_M_AXIS_TDATA_WIDTH +: C_M_AXIS_TDATA_WIDTH];
            end
            // Clear so a short result frame leaves zeros, not the previous frame's words.
            for (int k = 0; k < int'(NUMBER_OF_RESULT_WORDS); k++) r_result[k] <= '0;
            r_rx_error <= 1'b0;
            r_tx_ptr   <= '0;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_m00_hs) begin
            if (r_tx_ptr == TX_LAST) begin
              r_rx_ptr <= '0;
              r_state  <= S_WAIT_RESULT;
            end else begin
              r_tx_ptr <= r_tx_ptr + 1'b1;
            end
          end
        end
        S_WAIT_RESULT: begin
          if (w_s00_hs) begin
            r_result[r_rx_ptr] <= s00_axis_tdata;
            if (s00_axis_tlast) begin
              r_rx_error <= (r_rx_ptr != RX_LAST);
              r_state    <= S_HOLD;
            end else if (r_rx_ptr == RX_LAST) begin
              // Long frame: buffer is full, swallow the rest up to tlast.
              r_rx_error <= 1'b1;
              r_state    <= S_DRAIN;
            end else begin
              r_rx_ptr <= r_rx_ptr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_s00_hs && s00_axis_tlast) r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (result_ready) begin
            r_jobs_done <= r_jobs_done + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_job_feeder.sv
module tb_axis_job_feeder;

  localparam int NJ = 20;
  localparam int NR = 8;

  logic              axis_aclk = 1'b0;
  logic              axis_aresetn;
  logic [NJ*32-1:0]  job_data;
  logic              job_valid;
  logic              job_ready;
  logic              m00_axis_tvalid;
  logic [31:0]       m00_axis_tdata;
  logic [3:0]        m00_axis_tstrb;
  logic              m00_axis_tlast;
  logic              m00_axis_tready;
  logic              s00_axis_tready;
  logic [31:0]       s00_axis_tdata;
  logic [3:0]        s00_axis_tstrb;
  logic              s00_axis_tlast;
  logic              s00_axis_tvalid;
  logic [NR*32-1:0]  result_data;
  logic              result_valid;
  logic              result_ready;
  logic              rx_error;
  logic [15:0]       jobs_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 axis_aclk = ~axis_aclk;

  axis_job_feeder dut (
    .axis_aclk       (axis_aclk),
    .axis_aresetn    (axis_aresetn),
    .job_data        (job_data),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tstrb  (m00_axis_tstrb),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tready (m00_axis_tready),
    .s00_axis_tready (s00_axis_tready),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tstrb  (s00_axis_tstrb),
    .s00_axis_tlast  (s00_axis_tlast),
    .s00_axis_tvalid (s00_axis_tvalid),
    .result_data     (result_data),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .rx_error        (rx_error),
    .jobs_done       (jobs_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer a job whose word j is base+j; scramble job_data afterwards to show it is not re-read.
  task automatic offer_job(input logic [31:0] base);
    @(negedge axis_aclk);
    check("job_ready_idle", {31'd0, job_ready}, 32'd1);
    for (int j = 0; j < NJ; j++) job_data[j*32 +: 32] = base + j;
    job_valid = 1'b1;
    @(posedge axis_aclk);
    #1;
    job_valid = 1'b0;
    job_data  = {NJ{32'hDEAD_BEEF}};
  endtask

  // Consume job words up to index stop_at; each sampled cycle must show the expected word.
  task automatic run_job(input logic [31:0] base, input bit rnd, input int stop_at,
                         output int cycles);
    int idx = 0;
    int t   = 0;
    cycles = 0;
    while (idx < stop_at && t < 1000) begin
      @(negedge axis_aclk);
      t++;
      cycles++;
      check("m00_tvalid", {31'd0, m00_axis_tvalid}, 32'd1);
      check("m00_tdata", m00_axis_tdata, base + idx);
      check("m00_tlast", {31'd0, m00_axis_tlast}, (idx == NJ - 1) ? 32'd1 : 32'd0);
      m00_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m00_axis_tready) idx++;
    end
    if (idx < stop_at) check("m00_timeout", idx, stop_at);
    @(posedge axis_aclk);
    #1;
    m00_axis_tready = 1'b1;
  endtask

  task automatic send_result(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      s00_axis_tvalid = 1'b1;
      s00_axis_tdata  = 32'hA0 + k;
      s00_axis_tlast  = (k == n - 1);
      t = 0;
      do begin
        @(negedge axis_aclk);
        t++;
      end while (!s00_axis_tready && t < 50);
      if (!s00_axis_tready) check("s00_tready_timeout", {31'd0, s00_axis_tready}, 32'd1);
      check("m00_tvalid_off", {31'd0, m00_axis_tvalid}, 32'd0);
      @(posedge axis_aclk);
      #1;
    end
    s00_axis_tvalid = 1'b0;
    s00_axis_tlast  = 1'b0;
  endtask

  task automatic check_result(input int nvalid, input logic exp_err);
    @(negedge axis_aclk);
    check("result_valid", {31'd0, result_valid}, 32'd1);
    check("rx_error", {31'd0, rx_error}, {31'd0, exp_err});
    for (int k = 0; k < NR; k++) begin
      check($sformatf("result_word%0d", k), result_data[k*32 +: 32],
            (k < nvalid) ? 32'hA0 + k : 32'd0);
    end
  endtask

  task automatic finish_hold(input int hold_cycles, input logic [15:0] exp_jobs);
    for (int c = 0; c < hold_cycles; c++) begin
      @(negedge axis_aclk);
      check("hold_result_valid", {31'd0, result_valid}, 32'd1);
      check("hold_job_ready", {31'd0, job_ready}, 32'd0);
      check("hold_s00_tready", {31'd0, s00_axis_tready}, 32'd0);
    end
    result_ready = 1'b1;
    @(posedge axis_aclk);
    #1;
    result_ready = 1'b0;
    @(negedge axis_aclk);
    check("idle_job_ready", {31'd0, job_ready}, 32'd1);
    check("idle_result_valid", {31'd0, result_valid}, 32'd0);
    check("jobs_done", {16'd0, jobs_done}, {16'd0, exp_jobs});
  endtask

  task automatic check_reset_outputs();
    check("rst_job_ready", {31'd0, job_ready}, 32'd1);
    check("rst_m00_tvalid", {31'd0, m00_axis_tvalid}, 32'd0);
    check("rst_s00_tready", {31'd0, s00_axis_tready}, 32'd0);
    check("rst_result_valid", {31'd0, result_valid}, 32'd0);
    check("rst_rx_error", {31'd0, rx_error}, 32'd0);
    check("rst_jobs_done", {16'd0, jobs_done}, 32'd0);
  endtask

  initial begin
    int cyc;
    axis_aresetn    = 1'b0;
    job_data        = '0;
    job_valid       = 1'b0;
    m00_axis_tready = 1'b1;
    s00_axis_tdata  = '0;
    s00_axis_tstrb  = '0;
    s00_axis_tlast  = 1'b0;
    s00_axis_tvalid = 1'b0;
    result_ready    = 1'b0;
    #1;
    check_reset_outputs();
    check("tstrb", {28'd0, m00_axis_tstrb}, 32'hF);
    repeat (2) @(negedge axis_aclk);
    axis_aresetn = 1'b1;

    // Basic round trip, full ready, 20 back-to-back words, then a 10-cycle hold.
    offer_job(32'h100);
    run_job(32'h100, 1'b0, NJ, cyc);
    check("send_cycles", cyc, NJ);
    send_result(NR);
    check_result(NR, 1'b0);
    finish_hold(10, 16'd1);

    // Random downstream backpressure.
    offer_job(32'h300);
    run_job(32'h300, 1'b1, NJ, cyc);
    send_result(NR);
    check_result(NR, 1'b0);
    finish_hold(1, 16'd2);

    // Long frame: 10 words, last two discarded.
    offer_job(32'h500);
    run_job(32'h500, 1'b0, NJ, cyc);
    send_result(10);
    check_result(NR, 1'b1);
    finish_hold(2, 16'd3);

    // Short frame after a full one: words 5..7 must read back as zero.
    offer_job(32'h700);
    run_job(32'h700, 1'b1, NJ, cyc);
    send_result(5);
    check_result(5, 1'b1);
    finish_hold(1, 16'd4);

    // Reset while word 7 is on the bus.
    offer_job(32'h900);
    run_job(32'h900, 1'b0, 7, cyc);
    @(negedge axis_aclk);
    check("pre_rst_tdata", m00_axis_tdata, 32'h907);
    axis_aresetn = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge axis_aclk);
    axis_aresetn = 1'b1;
    offer_job(32'h200);
    run_job(32'h200, 1'b0, NJ, cyc);
    check("send_cycles_after_rst", cyc, NJ);
    send_result(NR);
    check_result(NR, 1'b0);
    finish_hold(1, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
